// File: rtl/midi_out.sv
// MIDI serial transmitter: byte FIFO feeding an 8N1 UART shifter.
// The line idles high; queued frames go out back-to-back with no idle gap.
module midi_out #(
  parameter int CLKS_PER_BIT = 1600,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic [7:0]                    byteInput,
  input  logic                          byteInputValid,
  output logic                          byteInputReady,
  output logic                          uartStream,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TICK_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]        fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [1:0]        state;
  logic [TICK_W-1:0] tickCount;
  logic [2:0]        bitIndex;
  logic [7:0]        shiftReg;
  logic              push;
  logic              pop;
  logic              bitEnd;
  logic              fifoEmpty;

  // A pop on this edge cannot make a full FIFO ready; ready looks only at the count.
  assign byteInputReady = (fifoCount != FULL_COUNT);
  assign fifoEmpty      = (fifoCount == '0);
  assign bitEnd         = (tickCount == LAST_TICK);
  assign push           = byteInputValid && byteInputReady;
  assign pop            = !fifoEmpty && ((state == IDLE) || ((state == STOP) && bitEnd));
  assign busy           = (state != IDLE) || !fifoEmpty;

  // NOTE: the byte storage has no reset; contents are meaningless until the
  // pointers say otherwise, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (resetN && push) begin
      fifoMem[wrPtr] <= byteInput;
    end
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // see the pre-edge values of each other, independent of statement order.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + CNT_W'(1);
        2'b01:   fifoCount <= fifoCount - CNT_W'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // Bit-period timer: parked at zero while idle so a popped frame starts a full period.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      tickCount <= '0;
    end else if ((state == IDLE) || bitEnd) begin
      tickCount <= '0;
    end else begin
      tickCount <= tickCount + TICK_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state      <= IDLE;
      bitIndex   <= '0;
      shiftReg   <= '0;
      uartStream <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shiftReg   <= fifoMem[rdPtr];
            state      <= START;
            uartStream <= 1'b0;
          end
        end
        START: begin
          if (bitEnd) begin
            state      <= DATA;
            bitIndex   <= '0;
            uartStream <= shiftReg[0];
            shiftReg   <= shiftReg >> 1;
          end
        end
        DATA: begin
          if (bitEnd) begin
            if (bitIndex == 3'd7) begin
              state      <= STOP;
              uartStream <= 1'b1;
            end else begin
              bitIndex   <= bitIndex + 3'd1;
              uartStream <= shiftReg[0];
              shiftReg   <= shiftReg >> 1;
            end
          end
        end
        STOP: begin
          if (bitEnd) begin
            if (pop) begin
              shiftReg   <= fifoMem[rdPtr];
              state      <= START;
              uartStream <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          uartStream <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/midi_out.md
MIDI_OUT -- requirements
Module: midi_out

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 1600, meaning clock cycles per serial bit (50 MHz / 31,250 baud); legal values are 2 or more.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the transmit FIFO depth in bytes; legal values are powers of 2, at least 2.
REQ-003 The block SHALL have port clock, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port resetN, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 The block SHALL have port byteInput, input, 8 bits: the MIDI byte to transmit.
REQ-006 The block SHALL have port byteInputValid, input, 1 bit: when high, byteInput holds a byte offered for transmission.
REQ-007 The block SHALL have port byteInputReady, output, 1 bit: high when the FIFO can accept a byte (FIFO not full).
REQ-008 The block SHALL have port uartStream, output, 1 bit: the serial MIDI line, registered, high when idle.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a frame is on the line or the FIFO is not empty.
REQ-010 The block SHALL have port fifoCount, output, clog2(FIFO_DEPTH)+1 bits: the number of bytes queued, excluding the frame currently being shifted.

Function
REQ-011 A byte SHALL be accepted only on a rising edge where byteInputValid and byteInputReady are both high; the byte is written to the FIFO tail.
REQ-012 An offer made while byteInputReady is low SHALL be ignored, with no change to the FIFO or to fifoCount.
REQ-013 byteInputReady SHALL be computed combinationally from fifoCount as (fifoCount != FIFO_DEPTH); a pop in the same cycle SHALL NOT make a full FIFO ready.
REQ-014 A push and a pop on the same edge SHALL leave fifoCount unchanged and SHALL preserve byte order.
REQ-015 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 The transmit FSM SHALL have four states: IDLE, START, DATA and STOP.
REQ-017 In IDLE with fifoCount > 0, the FSM SHALL pop the FIFO head into the shift register, go to START and drive uartStream low on that same edge.
REQ-018 The start bit, each of the 8 data bits, and the stop bit SHALL each last exactly CLKS_PER_BIT cycles.
REQ-019 A bit-period counter SHALL count 0 to CLKS_PER_BIT-1 and then wrap to 0, and the bit SHALL advance on that wrap.
REQ-020 In START, when the bit period ends, the FSM SHALL go to DATA and drive bit 0 (the LSB) of the byte.
REQ-021 In DATA, each bit-period end SHALL shift to the next bit, transmitting LSB first; after bit 7 ends, the FSM SHALL go to STOP and drive the line high.
REQ-022 In STOP, at the end of the bit period, the FSM SHALL go to START if fifoCount > 0, popping the next byte with no idle gap; otherwise it SHALL go to IDLE.
REQ-023 The frame SHALL be 8N1 (1 start bit, 8 data bits, no parity, 1 stop bit), with a total length of 10*CLKS_PER_BIT cycles.
REQ-024 Latency SHALL be one cycle: a byte accepted on edge k into an empty, idle block drives uartStream low from edge k+1.
REQ-025 busy SHALL be high when (state != IDLE) or (fifoCount != 0), and SHALL be registered or derived glitch-free from registered signals.
REQ-026 byteInput SHALL be sampled only at acceptance; changes to byteInput afterwards SHALL NOT affect any queued or in-flight byte.
REQ-027 The block SHALL NOT interpret MIDI content; status, data and system real-time bytes SHALL be transmitted verbatim and in order.

Reset
REQ-028 While resetN is low at a rising edge, the following SHALL hold on the next cycle: state=IDLE, uartStream=1, busy=0, fifoCount=0, byteInputReady=1, pointers=0, bit counter=0.
REQ-029 A reset asserted mid-frame SHALL abort the frame, return the line high on the next cycle, and discard all queued bytes.
REQ-030 A byte offered in the same cycle that resetN is low SHALL be discarded.
REQ-031 After resetN rises, the first acceptance SHALL be possible on the first edge with resetN high.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 Push 0x90 once into an idle block: uartStream SHALL go low at edge k+1, then show the bit sequence 0,0,0,0,0,1,0,0,1,1, each bit 4 cycles, with busy low at edge k+41.
REQ-033 Push 0x90, 0x3C, 0x7F back-to-back: the three frames SHALL be contiguous (120 cycles, no idle gap between stop and start), in order.
REQ-034 Hold byteInputValid high with 6 distinct bytes: byteInputReady SHALL fall when fifoCount=4, the rejected bytes SHALL never appear on the line, and the accepted bytes SHALL be transmitted in order.
REQ-035 Full FIFO with a pop coinciding with a push offer: the push SHALL be rejected, fifoCount SHALL go 4 to 3, and the next cycle SHALL accept the offer.
REQ-036 Pull resetN low during DATA bit 3: uartStream SHALL be 1 the next cycle, fifoCount and busy SHALL be 0, and a new push after release SHALL produce a clean frame.
REQ-037 Push 0xFF then 0x00: the line SHALL show a low start bit with all-high data for 0xFF, and a 9-bit low run for 0x00 followed by a high stop bit.
